// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg
//   Shared definitions for the instruction fetch sequencer: FSM state
//   encoding, instruction width, PC increment and PC alignment helper.
package fetch_sequencer_pkg;

    localparam int          INSTR_W = 32;
    localparam logic [31:0] PC_INC  = 32'd4;

    typedef enum logic [2:0] {
        FS_IDLE    = 3'd0,
        FS_REQ     = 3'd1,
        FS_HOLD    = 3'd2,
        FS_DISCARD = 3'd3,
        FS_FAULT   = 3'd4
    } fs_state_t;

    // Instructions are word aligned; the two low address bits are dropped.
    function automatic logic [INSTR_W-1:0] align_pc(input logic [INSTR_W-1:0] pc);
        return {pc[INSTR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// fetch_watchdog
//   Counts cycles a memory request waits for its acknowledge and flags a
//   timeout on the last permitted waiting cycle.
// Ports
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   clear    in  restart the count (new request, ack, state change)
//   count_en in  request pending and not acknowledged this cycle
//   timeout  out this waiting cycle is the TIMEOUT_CYCLES-th one
module fetch_watchdog #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (count_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign timeout = count_en && (r_count == LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Owns the PC, issues one memory read per instruction over req/ack,
//   presents the fetched word to decode over valid/ready, handles branch
//   redirects (flushing the fetch in flight) and faults on memory timeout.
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   enable                         fetch permitted (only gates new requests)
//   redirect_valid, redirect_pc    one-cycle redirect to a new PC
//   mem_req, mem_addr              read request and its address (registered)
//   mem_ack, mem_rdata             read completion and instruction word
//   instr_valid, instr, instr_pc   fetched instruction to decode (registered)
//   instr_ready                    decode accepts the instruction
//   fetch_fault                    sticky memory-timeout flag
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16,
    parameter int          CNT_W          = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               mem_req,
    output logic [31:0]        mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        instr_pc,
    input  logic               instr_ready,
    output logic               fetch_fault
);

    fs_state_t          r_state, w_state_nxt;
    logic [31:0]        r_pc, w_pc_nxt;
    logic               r_mem_req, w_mem_req_nxt;
    logic [31:0]        r_mem_addr, w_mem_addr_nxt;
    logic               r_instr_valid, w_instr_valid_nxt;
    logic [INSTR_W-1:0] r_instr, w_instr_nxt;
    logic [31:0]        r_instr_pc, w_instr_pc_nxt;
    logic               r_fault, w_fault_nxt;

    logic               w_ack;
    logic               w_start;
    logic               w_timeout;
    logic               w_wd_clear;
    logic               w_wd_count;
    logic [31:0]        w_redirect_pc;

    // An ack only counts while a request is outstanding.
    assign w_ack         = r_mem_req && mem_ack;
    assign w_redirect_pc = align_pc(redirect_pc);
    assign w_wd_count    = r_mem_req && !mem_ack;
    assign w_wd_clear    = w_ack || w_start || (w_state_nxt != r_state);

    fetch_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_wd_clear),
        .count_en (w_wd_count),
        .timeout  (w_timeout)
    );

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_mem_req_nxt     = r_mem_req;
        w_mem_addr_nxt    = r_mem_addr;
        w_instr_valid_nxt = r_instr_valid;
        w_instr_nxt       = r_instr;
        w_instr_pc_nxt    = r_instr_pc;
        w_fault_nxt       = r_fault;
        w_start           = 1'b0;

        case (r_state)
            FS_IDLE: begin
                if (redirect_valid) w_pc_nxt = w_redirect_pc;
                w_start = enable;
            end
            FS_REQ: begin
                if (redirect_valid) begin
                    w_pc_nxt = w_redirect_pc;
                    if (w_ack) begin
                        // Returned word belongs to the old stream: drop it.
                        w_mem_req_nxt = 1'b0;
                        w_state_nxt   = FS_IDLE;
                        w_start       = enable;
                    end else begin
                        // The request cannot be withdrawn; absorb its ack later.
                        w_state_nxt = FS_DISCARD;
                    end
                end else if (w_ack) begin
                    w_instr_nxt       = mem_rdata;
                    w_instr_pc_nxt    = r_pc;
                    w_instr_valid_nxt = 1'b1;
                    w_mem_req_nxt     = 1'b0;
                    w_state_nxt       = FS_HOLD;
                end else if (w_timeout) begin
                    w_mem_req_nxt = 1'b0;
                    w_fault_nxt   = 1'b1;
                    w_state_nxt   = FS_FAULT;
                end
            end
            FS_HOLD: begin
                // A redirect wins over a same-cycle handshake: no PC increment.
                if (redirect_valid || instr_ready) begin
                    w_pc_nxt          = redirect_valid ? w_redirect_pc : r_pc + PC_INC;
                    w_instr_valid_nxt = 1'b0;
                    w_state_nxt       = FS_IDLE;
                    w_start           = enable;
                end
            end
            FS_DISCARD: begin
                if (redirect_valid) w_pc_nxt = w_redirect_pc;
                if (w_ack) begin
                    w_mem_req_nxt = 1'b0;
                    w_state_nxt   = FS_IDLE;
                    w_start       = enable;
                end else if (w_timeout && !redirect_valid) begin
                    w_mem_req_nxt = 1'b0;
                    w_fault_nxt   = 1'b1;
                    w_state_nxt   = FS_FAULT;
                end
            end
            FS_FAULT: begin
                if (redirect_valid) begin
                    w_pc_nxt    = w_redirect_pc;
                    w_fault_nxt = 1'b0;
                    w_state_nxt = FS_IDLE;
                    w_start     = enable;
                end
            end
            default: begin
                w_state_nxt = FS_IDLE;
            end
        endcase

        // Common entry into REQ: raise the request at the (possibly new) PC.
        if (w_start) begin
            w_state_nxt    = FS_REQ;
            w_mem_req_nxt  = 1'b1;
            w_mem_addr_nxt = w_pc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FS_IDLE;
            r_pc          <= RESET_PC;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= RESET_PC;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_fault       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_mem_req     <= w_mem_req_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_fault       <= w_fault_nxt;
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign fetch_fault = r_fault;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Randomised and directed stimulus for fetch_sequencer.  The reference
//   model is the architectural instruction stream: starting at the reset PC,
//   every accepted instruction advances it by 4 and every redirect replaces
//   it.  Memory contents are a fixed function of the address.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TIMEOUT  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        fetch_fault;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .RESET_PC       (RESET_PC),
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .fetch_fault    (fetch_fault)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    function automatic void push_exp(input logic [31:0] p);
        exp_t x;
        x.pc   = p;
        x.word = mem_word(p);
        exp_q.push_back(x);
    endfunction

    logic        prev_req = 1'b0, prev_ack = 1'b0, prev_rst = 1'b0;
    logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_redir = 1'b0;
    logic [31:0] prev_addr = 32'h0, prev_instr = 32'h0, prev_ipc = 32'h0;
    bit          fault_allowed = 1'b0;
    int          n_hs = 0;

    // Monitor: samples on the falling edge and predicts the coming rising edge.
    always @(negedge clk) begin
        if (prev_rst) begin
            check32("rst_mem_req", {31'h0, mem_req}, 32'h0);
            check32("rst_mem_addr", mem_addr, RESET_PC);
            check32("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
            check32("rst_instr", instr, 32'h0);
            check32("rst_instr_pc", instr_pc, 32'h0);
            check32("rst_fault", {31'h0, fetch_fault}, 32'h0);
        end else begin
            if (prev_req && !prev_ack && !fetch_fault) begin
                check32("req_held", {31'h0, mem_req}, 32'h1);
                check32("addr_stable", mem_addr, prev_addr);
            end
            if (mem_req && (!prev_req || prev_ack)) begin
                if (exp_q.size() == 0) begin
                    check32("req_addr_noexp", 32'h1, 32'h0);
                end else begin
                    check32("req_addr", mem_addr, exp_q[0].pc);
                end
            end
            if (prev_valid && !prev_ready && !prev_redir) begin
                check32("hold_valid", {31'h0, instr_valid}, 32'h1);
                check32("hold_instr", instr, prev_instr);
                check32("hold_pc", instr_pc, prev_ipc);
            end
            if (prev_valid && (prev_ready || prev_redir)) begin
                check32("valid_drop", {31'h0, instr_valid}, 32'h0);
            end
            if (!fault_allowed) begin
                check32("no_fault", {31'h0, fetch_fault}, 32'h0);
            end
        end

        if (rst) begin
            exp_q.delete();
            push_exp(RESET_PC);
        end else if (redirect_valid) begin
            exp_q.delete();
            push_exp(redirect_pc & ~32'h3);
        end else if (instr_valid && instr_ready) begin
            n_hs++;
            if (exp_q.size() == 0) begin
                check32("hs_noexp", 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check32("hs_pc", instr_pc, e.pc);
                check32("hs_instr", instr, e.word);
                push_exp(e.pc + 32'd4);
            end
        end

        prev_req   = mem_req;
        prev_ack   = mem_ack;
        prev_rst   = rst;
        prev_valid = instr_valid;
        prev_ready = instr_ready;
        prev_redir = redirect_valid;
        prev_addr  = mem_addr;
        prev_instr = instr;
        prev_ipc   = instr_pc;
    end

    // ---------------- memory responder ----------------
    int ack_delay   = -1;
    int fixed_delay = 0;
    int max_delay   = 0;
    bit never_ack   = 1'b0;
    bit spurious    = 1'b0;

    task automatic mem_respond();
        if (mem_req !== 1'b1) begin
            ack_delay = -1;
            mem_ack   = spurious && ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
        end else begin
            if (ack_delay < 0) begin
                ack_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, max_delay));
            end
            if (never_ack) begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end else if (ack_delay == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
                ack_delay = -1;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                ack_delay--;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        mem_respond();
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (instr_valid !== 1'b1 && k < 200) begin
            cyc();
            k++;
        end
        n_chk++;
        if (instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: instr_valid still %b after %0d cycles, required 1", name, instr_valid, k);
        end
    endtask

    task automatic wait_req_rise(input string name);
        int   k = 0;
        logic p;
        do begin
            p = mem_req;
            cyc();
            k++;
        end while (!(mem_req === 1'b1 && p === 1'b0) && k < 200);
        n_chk++;
        if (!(mem_req === 1'b1 && p === 1'b0)) begin
            n_fail++;
            $display("FAIL %s: mem_req did not rise within %0d cycles", name, k);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] saved_pc, saved_instr, saved_addr;
        int          k, hs0;

        repeat (3) cyc();
        check32("t0_mem_addr", mem_addr, RESET_PC);
        check32("t0_mem_req", {31'h0, mem_req}, 32'h0);

        // 1: streaming with same-cycle ack
        rst = 1'b0; enable = 1'b1; instr_ready = 1'b1; fixed_delay = 0;
        wait_valid("t1_first");
        check32("t1_first_pc", instr_pc, RESET_PC);
        check32("t1_first_instr", instr, mem_word(RESET_PC));
        repeat (4) cyc();
        hs0 = n_hs;
        repeat (20) cyc();
        check32("t1_throughput", n_hs - hs0, 32'd10);

        // 2: decode stalls for 5 cycles
        wait_valid("t2_valid");
        instr_ready = 1'b0;
        saved_pc    = instr_pc;
        saved_instr = instr;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check32("t2_stall_valid", {31'h0, instr_valid}, 32'h1);
            check32("t2_stall_pc", instr_pc, saved_pc);
            check32("t2_stall_instr", instr, saved_instr);
            check32("t2_stall_noreq", {31'h0, mem_req}, 32'h0);
        end
        instr_ready = 1'b1;
        cyc();
        check32("t2_accept_drop", {31'h0, instr_valid}, 32'h0);
        wait_valid("t2_next");
        check32("t2_next_pc", instr_pc, saved_pc + 32'd4);

        // 3: redirect while a request waits for its ack
        fixed_delay = 3;
        wait_req_rise("t3_rise");
        cyc();
        saved_addr     = mem_addr;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1002;
        cyc();
        redirect_valid = 1'b0;
        check32("t3_discard_req", {31'h0, mem_req}, 32'h1);
        check32("t3_discard_addr", mem_addr, saved_addr);
        wait_valid("t3_valid");
        check32("t3_pc", instr_pc, 32'h0000_1000);
        check32("t3_instr", instr, mem_word(32'h0000_1000));
        fixed_delay = 0;

        // 4: redirect in HOLD with a same-cycle ready
        wait_valid("t4_valid");
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2000;
        cyc();
        redirect_valid = 1'b0;
        check32("t4_valid_drop", {31'h0, instr_valid}, 32'h0);
        wait_valid("t4_next");
        check32("t4_pc", instr_pc, 32'h0000_2000);

        // 5: memory never acknowledges
        enable = 1'b0;
        repeat (8) cyc();
        check32("t5_idle_req", {31'h0, mem_req}, 32'h0);
        never_ack = 1'b1; fault_allowed = 1'b1; enable = 1'b1;
        cyc();
        check32("t5_req_up", {31'h0, mem_req}, 32'h1);
        k = 1;
        while (mem_req === 1'b1 && k < 40) begin
            cyc();
            if (mem_req === 1'b1) k++;
        end
        check32("t5_wait_cycles", k, TIMEOUT);
        check32("t5_fault", {31'h0, fetch_fault}, 32'h1);
        repeat (3) cyc();
        check32("t5_fault_sticky", {31'h0, fetch_fault}, 32'h1);
        check32("t5_fault_noreq", {31'h0, mem_req}, 32'h0);
        never_ack      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        cyc();
        redirect_valid = 1'b0;
        check32("t5_fault_clear", {31'h0, fetch_fault}, 32'h0);
        check32("t5_new_req", {31'h0, mem_req}, 32'h1);
        check32("t5_new_addr", mem_addr, 32'h0000_0040);
        fault_allowed = 1'b0;

        // 6: PC wrap, then reset in the middle of a request
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        cyc();
        redirect_valid = 1'b0;
        wait_valid("t6_top");
        check32("t6_top_pc", instr_pc, 32'hFFFF_FFFC);
        cyc();
        wait_valid("t6_wrap");
        check32("t6_wrap_pc", instr_pc, 32'h0000_0000);
        fixed_delay = 5;
        wait_req_rise("t6_rise");
        cyc();
        rst = 1'b1;
        cyc();
        check32("t6_rst_req", {31'h0, mem_req}, 32'h0);
        check32("t6_rst_addr", mem_addr, RESET_PC);
        check32("t6_rst_valid", {31'h0, instr_valid}, 32'h0);
        check32("t6_rst_instr", instr, 32'h0);
        check32("t6_rst_ipc", instr_pc, 32'h0);
        check32("t6_rst_fault", {31'h0, fetch_fault}, 32'h0);
        rst = 1'b0;

        // 7: randomised traffic
        fixed_delay = -1; max_delay = 5; spurious = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            enable         = ($urandom_range(0, 9) != 0);
            instr_ready    = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 29) == 0);
            redirect_pc    = $urandom & 32'h0000_FFFF;
            cyc();
        end
        redirect_valid = 1'b0;
        enable         = 1'b0;
        instr_ready    = 1'b1;
        repeat (20) cyc();
        check32("t7_drained_req", {31'h0, mem_req}, 32'h0);
        check32("t7_drained_valid", {31'h0, instr_valid}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
